riscv_wb_stage: RTL and testbench

Writeback stage that sits downstream of the EX stage and consumes its ex_valid/wb_ready handshake. It captures retiring register writes from EX and commits them to the register file write port. ALU/CSR/mult results take one cycle. Loads wait for the LSU response, then have their byte lanes extracted and sign/zero-extended. A load timeout counter drops a hung load and flags an error.

---
 rtl/riscv_wb_stage_pkg.sv | 14 +
 rtl/riscv_load_align.sv | 35 +++
 rtl/riscv_wb_stage.sv | 149 ++++++++++++++
 tb/tb_riscv_wb_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_stage_pkg.sv
// Shared definitions for the writeback stage and the load aligner:
// load size encodings and the writeback state type.
package riscv_defines;

  localparam logic [1:0] LOAD_WORD = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_BYTE = 2'b10;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: picks the addressed half/byte lane out of a raw
// aligned load word and sign- or zero-extends it to 32 bits. The reserved
// size encoding behaves like a word load. Kept standalone so the LSU can
// reuse it.
module riscv_load_align
  import riscv_defines::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  load_type,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lsb,
  output logic [31:0] result
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Lane selection followed by extension to the full register width
  always_comb begin
    half_lane = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lsb)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    case (load_type)
      LOAD_WORD: result = rdata;
      LOAD_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
      LOAD_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// RISC-V writeback stage. Non-load results are registered and written one
// cycle after acceptance; loads park in WB_WAIT_LOAD until the LSU responds,
// at which point the aligned data is written in the same cycle. A load that
// sees no response for LOAD_TIMEOUT cycles is dropped and load_err_o pulses.
// Optional macro DIFT_WB_EN adds a one-bit taint tag travelling with the data.
module riscv_wb_stage
  import riscv_defines::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        wb_ready_o,
  input  logic        regfile_we_i,
  input  logic [4:0]  regfile_waddr_i,
  input  logic [31:0] regfile_wdata_i,
  input  logic        is_load_i,
  input  logic [1:0]  load_type_i,
  input  logic        load_sign_ext_i,
  input  logic [1:0]  load_addr_lsb_i,
  input  logic        lsu_rvalid_i,
  input  logic [31:0] lsu_rdata_i,
`ifdef DIFT_WB_EN
  input  logic        regfile_wdata_i_tag,
  input  logic        lsu_rdata_i_tag,
  output logic        regfile_wdata_o_tag,
`endif
  output logic        regfile_we_o,
  output logic [4:0]  regfile_waddr_o,
  output logic [31:0] regfile_wdata_o,
  output logic        load_err_o
);

  wb_state_t            state_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic        ld_we_q;
  logic [4:0]  ld_waddr_q;
  logic [1:0]  ld_type_q;
  logic        ld_sext_q;
  logic [1:0]  ld_lsb_q;

  logic        nl_we_q;
  logic [4:0]  nl_waddr_q;
  logic [31:0] nl_wdata_q;
  logic        err_q;

  logic        in_wait;
  logic        load_done;
  logic        timeout;
  logic        accept;
  logic [31:0] load_data;

`ifdef DIFT_WB_EN
  logic        nl_tag_q;
`endif

  assign in_wait    = (state_q == WB_WAIT_LOAD);
  assign load_done  = in_wait & lsu_rvalid_i;
  assign timeout    = in_wait & ~lsu_rvalid_i &
                      (cnt_q == CNT_WIDTH'(LOAD_TIMEOUT - 1));
  assign wb_ready_o = ~in_wait | lsu_rvalid_i;
  assign accept     = ex_valid_i & wb_ready_o;
  assign load_err_o = err_q;

  riscv_load_align u_align (
    .rdata     (lsu_rdata_i),
    .load_type (ld_type_q),
    .sign_ext  (ld_sext_q),
    .addr_lsb  (ld_lsb_q),
    .result    (load_data)
  );

  // Load tracking: enter WAIT_LOAD on a load accept, leave on response or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      ld_we_q    <= 1'b0;
      ld_waddr_q <= '0;
      ld_type_q  <= LOAD_WORD;
      ld_sext_q  <= 1'b0;
      ld_lsb_q   <= '0;
    end else if (accept & is_load_i) begin
      state_q    <= WB_WAIT_LOAD;
      cnt_q      <= '0;
      ld_we_q    <= regfile_we_i & (regfile_waddr_i != 5'd0);
      ld_waddr_q <= regfile_waddr_i;
      ld_type_q  <= load_type_i;
      ld_sext_q  <= load_sign_ext_i;
      ld_lsb_q   <= load_addr_lsb_i;
    end else if (load_done | timeout) begin
      state_q <= WB_IDLE;
    end else if (in_wait) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Non-load results are registered so their write lands exactly one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      nl_we_q    <= 1'b0;
      nl_waddr_q <= '0;
      nl_wdata_q <= '0;
    end else begin
      nl_we_q <= accept & ~is_load_i & regfile_we_i & (regfile_waddr_i != 5'd0);
      if (accept & ~is_load_i) begin
        nl_waddr_q <= regfile_waddr_i;
        nl_wdata_q <= regfile_wdata_i;
      end
    end
  end

  // Timeout error is a single-cycle pulse in the cycle after the drop
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= timeout;
  end

  // Write port mux: aligned load data while waiting, registered result otherwise
  always_comb begin
    if (in_wait) begin
      regfile_we_o    = load_done & ld_we_q & ~rst;
      regfile_waddr_o = ld_waddr_q;
      regfile_wdata_o = load_data;
    end else begin
      regfile_we_o    = nl_we_q;
      regfile_waddr_o = nl_waddr_q;
      regfile_wdata_o = nl_wdata_q;
    end
  end

`ifdef DIFT_WB_EN
  // Non-load tag travels with its registered data; cleared when no non-load retires
  always_ff @(posedge clk) begin
    if (rst) nl_tag_q <= 1'b0;
    else     nl_tag_q <= accept & ~is_load_i & regfile_wdata_i_tag;
  end

  // Load tag comes straight from the LSU response
  always_comb begin
    if (in_wait) regfile_wdata_o_tag = load_done & lsu_rdata_i_tag;
    else         regfile_wdata_o_tag = nl_tag_q;
  end
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Testbench for riscv_wb_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model. Build with +define+DIFT_WB_EN to also exercise the taint tag.
module tb_riscv_wb_stage;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic        wb_ready_o;
  logic        regfile_we_i;
  logic [4:0]  regfile_waddr_i;
  logic [31:0] regfile_wdata_i;
  logic        is_load_i;
  logic [1:0]  load_type_i;
  logic        load_sign_ext_i;
  logic [1:0]  load_addr_lsb_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        regfile_wdata_i_tag;
  logic        lsu_rdata_i_tag;
  logic        regfile_we_o;
  logic [4:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic        load_err_o;
`ifdef DIFT_WB_EN
  logic        regfile_wdata_o_tag;
`endif

  int n_pass;
  int n_total;
  bit check_en;

  riscv_wb_stage #(.LOAD_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .wb_ready_o      (wb_ready_o),
    .regfile_we_i    (regfile_we_i),
    .regfile_waddr_i (regfile_waddr_i),
    .regfile_wdata_i (regfile_wdata_i),
    .is_load_i       (is_load_i),
    .load_type_i     (load_type_i),
    .load_sign_ext_i (load_sign_ext_i),
    .load_addr_lsb_i (load_addr_lsb_i),
    .lsu_rvalid_i    (lsu_rvalid_i),
    .lsu_rdata_i     (lsu_rdata_i),
`ifdef DIFT_WB_EN
    .regfile_wdata_i_tag (regfile_wdata_i_tag),
    .lsu_rdata_i_tag     (lsu_rdata_i_tag),
    .regfile_wdata_o_tag (regfile_wdata_o_tag),
`endif
    .regfile_we_o    (regfile_we_o),
    .regfile_waddr_o (regfile_waddr_o),
    .regfile_wdata_o (regfile_wdata_o),
    .load_err_o      (load_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Extraction from the ISA's point of view: shift the addressed lane down,
  // mask it, then extend by arithmetic on the top bit.
  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] ltype,
                                          input logic sext, input logic [1:0] lsb);
    logic [31:0] v;
    if (ltype == 2'd1) begin
      v = (rdata >> (16 * int'(lsb[1]))) & 32'h0000FFFF;
      if (sext && v[15]) v = v | 32'hFFFF0000;
    end else if (ltype == 2'd2) begin
      v = (rdata >> (8 * int'(lsb))) & 32'h000000FF;
      if (sext && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Outstanding load transaction and the non-load write due this cycle
  bit          m_ld_pend;
  int          m_ld_age;
  bit          m_ld_we;
  logic [4:0]  m_ld_waddr;
  logic [1:0]  m_ld_type;
  bit          m_ld_sext;
  logic [1:0]  m_ld_lsb;
  bit          m_nl_valid;
  logic [4:0]  m_nl_waddr;
  logic [31:0] m_nl_wdata;
  bit          m_nl_tag;
  bit          m_err;

  logic        m_acc;
  logic        m_tmo;
  logic        exp_ready;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        exp_tag;

  assign m_acc     = ex_valid_i && (!m_ld_pend || lsu_rvalid_i);
  assign m_tmo     = m_ld_pend && !lsu_rvalid_i && (m_ld_age == TB_TIMEOUT - 1);
  assign exp_ready = !m_ld_pend || lsu_rvalid_i;
  assign exp_we    = m_ld_pend ? (lsu_rvalid_i && m_ld_we && (m_ld_waddr != 5'd0)) : m_nl_valid;
  assign exp_waddr = m_ld_pend ? m_ld_waddr : m_nl_waddr;
  assign exp_wdata = m_ld_pend ? extract(lsu_rdata_i, m_ld_type, m_ld_sext, m_ld_lsb) : m_nl_wdata;
  assign exp_tag   = m_ld_pend ? lsu_rdata_i_tag : m_nl_tag;

  // Model advance on every clock edge using the inputs held during the cycle
  always @(posedge clk) begin
    if (rst) begin
      m_ld_pend  <= 1'b0;
      m_ld_age   <= 0;
      m_nl_valid <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      m_err      <= m_tmo;
      m_nl_valid <= m_acc && !is_load_i && regfile_we_i && (regfile_waddr_i != 5'd0);
      if (m_acc && !is_load_i) begin
        m_nl_waddr <= regfile_waddr_i;
        m_nl_wdata <= regfile_wdata_i;
        m_nl_tag   <= regfile_wdata_i_tag;
      end
      if (m_acc && is_load_i) begin
        m_ld_pend  <= 1'b1;
        m_ld_age   <= 0;
        m_ld_we    <= regfile_we_i;
        m_ld_waddr <= regfile_waddr_i;
        m_ld_type  <= load_type_i;
        m_ld_sext  <= load_sign_ext_i;
        m_ld_lsb   <= load_addr_lsb_i;
      end else if (m_ld_pend && (lsu_rvalid_i || m_tmo)) begin
        m_ld_pend <= 1'b0;
      end else if (m_ld_pend) begin
        m_ld_age <= m_ld_age + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("model_ready", 32'(wb_ready_o), 32'(exp_ready));
      checkOutput("model_we", 32'(regfile_we_o), 32'(exp_we));
      checkOutput("model_err", 32'(load_err_o), 32'(m_err));
      if (exp_we) begin
        checkOutput("model_waddr", 32'(regfile_waddr_o), 32'(exp_waddr));
        checkOutput("model_wdata", regfile_wdata_o, exp_wdata);
`ifdef DIFT_WB_EN
        checkOutput("model_tag", 32'(regfile_wdata_o_tag), 32'(exp_tag));
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ev, input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic ld, input logic [1:0] ltype,
                               input logic sext, input logic [1:0] lsb, input logic rvalid,
                               input logic [31:0] rdata);
    ex_valid_i      = ev;
    regfile_we_i    = we;
    regfile_waddr_i = waddr;
    regfile_wdata_i = wdata;
    is_load_i       = ld;
    load_type_i     = ltype;
    load_sign_ext_i = sext;
    load_addr_lsb_i = lsb;
    lsu_rvalid_i    = rvalid;
    lsu_rdata_i     = rdata;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    regfile_wdata_i_tag = 1'b0;
    lsu_rdata_i_tag     = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_we", 32'(regfile_we_o), 32'd0);
    checkOutput("rst_waddr", 32'(regfile_waddr_o), 32'd0);
    checkOutput("rst_wdata", regfile_wdata_o, 32'd0);
    checkOutput("rst_err", 32'(load_err_o), 32'd0);
    checkOutput("rst_ready", 32'(wb_ready_o), 32'd1);
`ifdef DIFT_WB_EN
    checkOutput("rst_tag", 32'(regfile_wdata_o_tag), 32'd0);
`endif

    // Non-load write appears one cycle after accept, for one cycle
    nextCycle();
    applyStimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    @(negedge clk);
    checkOutput("nl_accept_ready", 32'(wb_ready_o), 32'd1);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("nl_we", 32'(regfile_we_o), 32'd1);
    checkOutput("nl_waddr", 32'(regfile_waddr_o), 32'd5);
    checkOutput("nl_wdata", regfile_wdata_o, 32'hDEADBEEF);
`ifdef DIFT_WB_EN
    checkOutput("nl_tag", 32'(regfile_wdata_o_tag), 32'd0);
`endif
    nextCycle();
    @(negedge clk);
    checkOutput("nl_pulse_end", 32'(regfile_we_o), 32'd0);

    // Signed byte load, lane 2, response on the third cycle
    nextCycle();
    applyStimulus(1, 1, 5'd7, 32'h0, 1, 2'd2, 1, 2'd2, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      idleInputs();
      @(negedge clk);
      checkOutput("ldb_wait_ready", 32'(wb_ready_o), 32'd0);
      checkOutput("ldb_wait_we", 32'(regfile_we_o), 32'd0);
    end
    nextCycle();
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 2'd0, 0, 2'd0, 1, 32'h12F45678);
    lsu_rdata_i_tag = 1'b1;
    @(negedge clk);
    checkOutput("ldb_we", 32'(regfile_we_o), 32'd1);
    checkOutput("ldb_waddr", 32'(regfile_waddr_o), 32'd7);
    checkOutput("ldb_wdata", regfile_wdata_o, 32'hFFFFFFF4);
    checkOutput("ldb_ready", 32'(wb_ready_o), 32'd1);
`ifdef DIFT_WB_EN
    checkOutput("ldb_tag", 32'(regfile_wdata_o_tag), 32'd1);
`endif
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("ldb_after_we", 32'(regfile_we_o), 32'd0);

    // Unsigned upper half load with a non-load accepted in the response cycle
    nextCycle();
    applyStimulus(1, 1, 5'd9, 32'h0, 1, 2'd1, 0, 2'd2, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 1, 5'd3, 32'h11112222, 0, 2'd0, 0, 2'd0, 1, 32'h8001ABCD);
    @(negedge clk);
    checkOutput("ldh_we", 32'(regfile_we_o), 32'd1);
    checkOutput("ldh_waddr", 32'(regfile_waddr_o), 32'd9);
    checkOutput("ldh_wdata", regfile_wdata_o, 32'h00008001);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("ldh_nl_we", 32'(regfile_we_o), 32'd1);
    checkOutput("ldh_nl_waddr", 32'(regfile_waddr_o), 32'd3);
    checkOutput("ldh_nl_wdata", regfile_wdata_o, 32'h11112222);
    nextCycle();
    @(negedge clk);
    checkOutput("ldh_nl_end", 32'(regfile_we_o), 32'd0);

    // Timeout: no response for TB_TIMEOUT cycles drops the load
    nextCycle();
    applyStimulus(1, 1, 5'd10, 32'h0, 1, 2'd0, 0, 2'd0, 0, 32'h0);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      nextCycle();
      idleInputs();
      @(negedge clk);
      checkOutput("tmo_wait_ready", 32'(wb_ready_o), 32'd0);
      checkOutput("tmo_wait_err", 32'(load_err_o), 32'd0);
    end
    nextCycle();
    @(negedge clk);
    checkOutput("tmo_err", 32'(load_err_o), 32'd1);
    checkOutput("tmo_we", 32'(regfile_we_o), 32'd0);
    checkOutput("tmo_ready", 32'(wb_ready_o), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("tmo_err_end", 32'(load_err_o), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 2'd0, 0, 2'd0, 1, 32'h55AA55AA);
    @(negedge clk);
    checkOutput("spurious_we", 32'(regfile_we_o), 32'd0);
    checkOutput("spurious_err", 32'(load_err_o), 32'd0);

    // Response on the last allowed cycle wins over the timeout
    nextCycle();
    applyStimulus(1, 1, 5'd11, 32'h0, 1, 2'd0, 0, 2'd0, 0, 32'h0);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      nextCycle();
      idleInputs();
    end
    nextCycle();
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 2'd0, 0, 2'd0, 1, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("edge_we", 32'(regfile_we_o), 32'd1);
    checkOutput("edge_wdata", regfile_wdata_o, 32'hCAFEF00D);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("edge_no_err", 32'(load_err_o), 32'd0);

    // Write to x0 is suppressed
    nextCycle();
    applyStimulus(1, 1, 5'd0, 32'h0BADF00D, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("x0_we", 32'(regfile_we_o), 32'd0);

    // Reset while a load is pending discards it; later response is spurious
    nextCycle();
    applyStimulus(1, 1, 5'd12, 32'h0, 1, 2'd0, 0, 2'd0, 0, 32'h0);
    nextCycle();
    idleInputs();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 2'd0, 0, 2'd0, 1, 32'h00001234);
    @(negedge clk);
    checkOutput("rstld_we", 32'(regfile_we_o), 32'd0);
    checkOutput("rstld_waddr", 32'(regfile_waddr_o), 32'd0);
    checkOutput("rstld_wdata", regfile_wdata_o, 32'd0);
    checkOutput("rstld_err", 32'(load_err_o), 32'd0);
    checkOutput("rstld_ready", 32'(wb_ready_o), 32'd1);

    // Randomized traffic, checked every cycle by the model comparison
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                    $urandom, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 99) < 25, $urandom);
      regfile_wdata_i_tag = $urandom_range(0, 1);
      lsu_rdata_i_tag     = $urandom_range(0, 1);
    end
    nextCycle();
    rst = 1'b0;
    idleInputs();
    repeat (TB_TIMEOUT + 2) nextCycle();
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
